// File: rtl/layer4_pkg.sv
// Shared definitions for the layer-4 block-0 weight sequencer: state encoding,
// per-layer default weight word counts and the datapath word width.
package layer4_pkg;

  localparam int DATA_WIDTH    = 32;
  localparam int W1_WORDS_DEF  = 131072;   // conv1: 256 in x 512 out x 1x1
  localparam int W2_WORDS_DEF  = 2359296;  // conv2: 512 x 512 x 3x3
  localparam int W3_WORDS_DEF  = 131072;   // conv3: 256 x 512 x 1x1
  localparam int CNT_WIDTH_DEF = 22;
  localparam int NUM_SEGS      = 3;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD1 = 3'd1;
  localparam logic [2:0] ST_LOAD2 = 3'd2;
  localparam logic [2:0] ST_LOAD3 = 3'd3;
  localparam logic [2:0] ST_READY = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    LOAD1 = ST_LOAD1,
    LOAD2 = ST_LOAD2,
    LOAD3 = ST_LOAD3,
    READY = ST_READY
  } state_t;

  // Maps a weight lane index (0 = conv1) to the state that feeds it.
  function automatic state_t seg_state(input int idx);
    case (idx)
      0:       return LOAD1;
      1:       return LOAD2;
      default: return LOAD3;
    endcase
  endfunction

endpackage

// File: rtl/weight_seg_counter.sv
// Word counter for one weight segment; flags the accepted word that completes
// the segment so the sequencer can move on without a bubble.
module weight_seg_counter #(
  parameter int CNT_WIDTH = 22
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inc,
  input  logic                 clear,
  input  logic [CNT_WIDTH-1:0] term,
  output logic                 last
);

  logic [CNT_WIDTH-1:0] count_reg;

  assign last = inc & (count_reg == term - CNT_WIDTH'(1));

  // Clear wins over inc so the final word of a segment restarts the count at 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (inc) begin
      count_reg <= count_reg + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/layer4_weight_sequencer.sv
// Steers one weight word stream to the conv1/conv2/conv3 weight ports in order,
// then opens the pixel gate once all three weight sets are resident.
module layer4_weight_sequencer #(
  parameter int DATA_WIDTH = layer4_pkg::DATA_WIDTH,
  parameter int W1_WORDS   = layer4_pkg::W1_WORDS_DEF,
  parameter int W2_WORDS   = layer4_pkg::W2_WORDS_DEF,
  parameter int W3_WORDS   = layer4_pkg::W3_WORDS_DEF,
  parameter int CNT_WIDTH  = layer4_pkg::CNT_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  w_valid_in,
  input  logic [DATA_WIDTH-1:0] w_in,
  output logic                  w_ready_out,
  output logic                  valid_weight_out1,
  output logic [DATA_WIDTH-1:0] weight_out1,
  output logic                  valid_weight_out2,
  output logic [DATA_WIDTH-1:0] weight_out2,
  output logic                  valid_weight_out3,
  output logic [DATA_WIDTH-1:0] weight_out3,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] pxl_in,
  output logic                  valid_pxl_out,
  output logic [DATA_WIDTH-1:0] pxl_out,
  output logic                  busy,
  output logic                  done,
  output logic                  loaded
);

  import layer4_pkg::*;

  state_t               state_reg;
  state_t               state_next;
  logic                 load_active;
  logic                 accept;
  logic                 seg_clear;
  logic                 seg_last;
  logic [CNT_WIDTH-1:0] seg_term;
  logic [NUM_SEGS-1:0]  lane_sel;

  logic                  done_reg;
  logic                  loaded_reg;
  logic                  valid_pxl_reg;
  logic [DATA_WIDTH-1:0] pxl_reg;

  assign load_active = (state_reg == LOAD1) || (state_reg == LOAD2) || (state_reg == LOAD3);
  assign accept      = w_valid_in & load_active;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // start is only looked at in IDLE/READY, so a pulse mid-load has no effect.
  always_comb begin
    state_next = state_reg;
    seg_clear  = 1'b0;
    case (state_reg)
      IDLE: begin
        seg_clear = 1'b1;
        if (start) state_next = LOAD1;
      end
      LOAD1: begin
        if (seg_last) begin
          state_next = LOAD2;
          seg_clear  = 1'b1;
        end
      end
      LOAD2: begin
        if (seg_last) begin
          state_next = LOAD3;
          seg_clear  = 1'b1;
        end
      end
      LOAD3: begin
        if (seg_last) begin
          state_next = READY;
          seg_clear  = 1'b1;
        end
      end
      READY: begin
        if (start) begin
          state_next = LOAD1;
          seg_clear  = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        seg_clear  = 1'b1;
      end
    endcase
  end

  // One shared counter; its terminal count follows the segment being loaded.
  always_comb begin
    seg_term = CNT_WIDTH'(W1_WORDS);
    case (state_reg)
      LOAD2:   seg_term = CNT_WIDTH'(W2_WORDS);
      LOAD3:   seg_term = CNT_WIDTH'(W3_WORDS);
      default: ;
    endcase
  end

  weight_seg_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_seg_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (accept),
    .clear (seg_clear),
    .term  (seg_term),
    .last  (seg_last)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SEGS; gi++) begin : g_lane
      logic                  valid_reg;
      logic [DATA_WIDTH-1:0] data_reg;

      assign lane_sel[gi] = accept && (state_reg == seg_state(gi));

      // Unselected lanes keep their last word; only the valid drops.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          valid_reg <= 1'b0;
          data_reg  <= '0;
        end else begin
          valid_reg <= lane_sel[gi];
          if (lane_sel[gi]) data_reg <= w_in;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_reg      <= 1'b0;
      loaded_reg    <= 1'b0;
      valid_pxl_reg <= 1'b0;
      pxl_reg       <= '0;
    end else begin
      done_reg      <= lane_sel[NUM_SEGS-1] & seg_last;
      valid_pxl_reg <= valid_in & loaded_reg;
      pxl_reg       <= pxl_in;
      if (lane_sel[NUM_SEGS-1] && seg_last) begin
        loaded_reg <= 1'b1;
      end else if (start && !load_active) begin
        loaded_reg <= 1'b0;
      end
    end
  end

  assign w_ready_out       = load_active;
  assign busy              = load_active;
  assign valid_weight_out1 = g_lane[0].valid_reg;
  assign weight_out1       = g_lane[0].data_reg;
  assign valid_weight_out2 = g_lane[1].valid_reg;
  assign weight_out2       = g_lane[1].data_reg;
  assign valid_weight_out3 = g_lane[2].valid_reg;
  assign weight_out3       = g_lane[2].data_reg;
  assign done              = done_reg;
  assign loaded            = loaded_reg;
  assign valid_pxl_out     = valid_pxl_reg;
  assign pxl_out           = pxl_reg;

endmodule

// File: tb/tb_layer4_weight_sequencer.sv
// Bench for layer4_weight_sequencer with small segment sizes (4/6/3 words).
`timescale 1ns/1ps
module tb_layer4_weight_sequencer;

  localparam int DW    = 32;
  localparam int W1    = 4;
  localparam int W2    = 6;
  localparam int W3    = 3;
  localparam int TOTAL = W1 + W2 + W3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          w_valid_in = 1'b0;
  logic [DW-1:0] w_in = '0;
  logic          valid_in = 1'b0;
  logic [DW-1:0] pxl_in = '0;
  logic          w_ready_out, busy, done, loaded, valid_pxl_out;
  logic          valid_weight_out1, valid_weight_out2, valid_weight_out3;
  logic [DW-1:0] weight_out1, weight_out2, weight_out3, pxl_out;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  layer4_weight_sequencer #(
    .DATA_WIDTH (DW),
    .W1_WORDS   (W1),
    .W2_WORDS   (W2),
    .W3_WORDS   (W3),
    .CNT_WIDTH  (22)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .w_valid_in        (w_valid_in),
    .w_in              (w_in),
    .w_ready_out       (w_ready_out),
    .valid_weight_out1 (valid_weight_out1),
    .weight_out1       (weight_out1),
    .valid_weight_out2 (valid_weight_out2),
    .weight_out2       (weight_out2),
    .valid_weight_out3 (valid_weight_out3),
    .weight_out3       (weight_out3),
    .valid_in          (valid_in),
    .pxl_in            (pxl_in),
    .valid_pxl_out     (valid_pxl_out),
    .pxl_out           (pxl_out),
    .busy              (busy),
    .done              (done),
    .loaded            (loaded)
  );

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: a load is just a running count of accepted words, and word n
  // belongs to conv1 / conv2 / conv3 according to which range n falls in.
  bit            m_loading, m_loaded, exp_done, exp_vpx;
  int            m_n;
  logic [3:1]    exp_v;
  logic [DW-1:0] exp_w [1:3];
  logic [DW-1:0] exp_pxl;

  function automatic int route(input int n);
    if (n < W1) return 1;
    if (n < W1 + W2) return 2;
    return 3;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_loading <= 1'b0;
      m_loaded  <= 1'b0;
      m_n       <= 0;
      exp_v     <= '0;
      exp_w[1]  <= '0;
      exp_w[2]  <= '0;
      exp_w[3]  <= '0;
      exp_done  <= 1'b0;
      exp_vpx   <= 1'b0;
      exp_pxl   <= '0;
    end else begin
      exp_v    <= '0;
      exp_done <= 1'b0;
      exp_vpx  <= valid_in && m_loaded;
      exp_pxl  <= pxl_in;
      if (m_loading && w_valid_in) begin
        exp_v[route(m_n)] <= 1'b1;
        exp_w[route(m_n)] <= w_in;
        m_n <= m_n + 1;
        if (m_n + 1 == TOTAL) begin
          m_loading <= 1'b0;
          m_loaded  <= 1'b1;
          exp_done  <= 1'b1;
        end
      end else if (!m_loading && start) begin
        m_loading <= 1'b1;
        m_n       <= 0;
        m_loaded  <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    chk("w_ready", w_ready_out, m_loading);
    chk("busy", busy, m_loading);
    chk("valid1", valid_weight_out1, exp_v[1]);
    chk("valid2", valid_weight_out2, exp_v[2]);
    chk("valid3", valid_weight_out3, exp_v[3]);
    chk("weight1", weight_out1, exp_w[1]);
    chk("weight2", weight_out2, exp_w[2]);
    chk("weight3", weight_out3, exp_w[3]);
    chk("done", done, exp_done);
    chk("loaded", loaded, m_loaded);
    chk("valid_pxl", valid_pxl_out, exp_vpx);
    chk("pxl", pxl_out, exp_pxl);
  end

  // Capture of delivered words for the literal per-scenario checks.
  int q1[$], q2[$], q3[$];
  int done_cnt;

  always @(negedge clk) begin
    if (valid_weight_out1) begin q1.push_back(int'(weight_out1)); $display("conv1 <= %h", weight_out1); end
    if (valid_weight_out2) begin q2.push_back(int'(weight_out2)); $display("conv2 <= %h", weight_out2); end
    if (valid_weight_out3) begin q3.push_back(int'(weight_out3)); $display("conv3 <= %h", weight_out3); end
    if (done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_caps();
    q1.delete();
    q2.delete();
    q3.delete();
    done_cnt = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input int first, input bit throttle);
    if (throttle) begin
      for (int c = 0; c < 2 * TOTAL; c++) begin
        w_valid_in = (c % 2 == 0);
        w_in       = DW'(first + c / 2);
        tick();
      end
    end else begin
      for (int i = 0; i < TOTAL; i++) begin
        w_valid_in = 1'b1;
        w_in       = DW'(first + i);
        tick();
      end
    end
    w_valid_in = 1'b0;
  endtask

  task automatic chk_lane(input string name, input int q[$], input int base, input int n);
    chk({name, "_count"}, DW'(q.size()), DW'(n));
    for (int i = 0; i < n && i < q.size(); i++) chk(name, DW'(q[i]), DW'(base + i));
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", w_ready_out, 1'b0);
    chk("rst_loaded", loaded, 1'b0);
    chk("rst_w1", weight_out1, '0);
    chk("rst_pxl", pxl_out, '0);
    reset = 1'b1;
    tick();

    // Pixels before any load are dropped
    valid_in = 1'b1;
    pxl_in   = 32'hA5;
    tick();
    chk("pre_vpx", valid_pxl_out, 1'b0);
    chk("pre_pxl", pxl_out, 32'hA5);
    valid_in = 1'b0;

    // Basic back-to-back load
    clear_caps();
    pulse_start();
    chk("basic_busy", busy, 1'b1);
    feed(1, 1'b0);
    chk("basic_done", done, 1'b1);
    chk("basic_v3", valid_weight_out3, 1'b1);
    chk("basic_w3", weight_out3, 32'd13);
    chk("basic_loaded", loaded, 1'b1);
    chk("basic_busy_end", busy, 1'b0);
    tick();
    chk("basic_done_pulse", done, 1'b0);
    chk_lane("basic_c1", q1, 1, 4);
    chk_lane("basic_c2", q2, 5, 6);
    chk_lane("basic_c3", q3, 11, 3);
    chk("basic_done_cnt", DW'(done_cnt), 32'd1);

    // Pixel gate open
    valid_in = 1'b1;
    pxl_in   = 32'hA5;
    tick();
    chk("post_vpx", valid_pxl_out, 1'b1);
    chk("post_pxl", pxl_out, 32'hA5);

    // Reload from READY with a throttled source; pixels held valid meanwhile
    clear_caps();
    pulse_start();
    chk("reload_loaded", loaded, 1'b0);
    tick();
    chk("reload_vpx_gated", valid_pxl_out, 1'b0);
    feed(101, 1'b1);
    valid_in = 1'b0;
    tick();
    chk_lane("thr_c1", q1, 101, 4);
    chk_lane("thr_c2", q2, 105, 6);
    chk_lane("thr_c3", q3, 111, 3);
    chk("thr_done_cnt", DW'(done_cnt), 32'd1);
    chk("thr_loaded", loaded, 1'b1);

    // start pulse during LOAD2 is ignored
    clear_caps();
    pulse_start();
    for (int i = 0; i < TOTAL; i++) begin
      w_valid_in = 1'b1;
      w_in       = DW'(201 + i);
      start      = (i == 6);
      tick();
    end
    start      = 1'b0;
    w_valid_in = 1'b0;
    tick();
    tick();
    chk_lane("busy_c1", q1, 201, 4);
    chk_lane("busy_c2", q2, 205, 6);
    chk_lane("busy_c3", q3, 211, 3);
    chk("busy_done_cnt", DW'(done_cnt), 32'd1);

    // Asynchronous reset in the middle of LOAD2
    clear_caps();
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      w_valid_in = 1'b1;
      w_in       = DW'(301 + i);
      tick();
    end
    w_in  = 32'd306;
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_ready", w_ready_out, 1'b0);
    chk("mid_rst_loaded", loaded, 1'b0);
    chk("mid_rst_v2", valid_weight_out2, 1'b0);
    chk("mid_rst_w1", weight_out1, '0);
    chk("mid_rst_w2", weight_out2, '0);
    tick();
    w_valid_in = 1'b0;
    reset      = 1'b1;
    tick();
    chk("post_rst_busy", busy, 1'b0);
    clear_caps();
    pulse_start();
    feed(401, 1'b0);
    tick();
    chk_lane("rst_c1", q1, 401, 4);
    chk_lane("rst_c2", q2, 405, 6);
    chk("rst_loaded_again", loaded, 1'b1);

    // Random traffic, checked cycle by cycle against the reference
    for (int c = 0; c < 800; c++) begin
      start      = ($urandom_range(0, 24) == 0);
      w_valid_in = ($urandom_range(0, 3) != 0);
      w_in       = $urandom;
      valid_in   = $urandom_range(0, 1) == 1;
      pxl_in     = $urandom;
      tick();
    end
    start      = 1'b0;
    w_valid_in = 1'b0;
    valid_in   = 1'b0;
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
